// File: rtl/text_line_sequencer_if.sv
// -----------------------------------------------------------------------------
// text_line_sequencer_if
//
// Purpose:
//   Groups the game-logic facing and text_display facing signals of
//   text_line_sequencer into one bundle. The master modport is the side that
//   drives the line (game logic / pixel timing); the slave modport is the
//   sequencer itself.
//
// Signals:
//   pixel_x    [9:0]     current horizontal pixel position
//   frame_tick           one-cycle pulse per frame (vblank start)
//   wr_en                buffer write strobe
//   wr_addr    [AW-1:0]  slot index to write, AW = $clog2(MAX_CHARS)
//   wr_char    [6:0]     ASCII code to write
//   wr_ready             writes are accepted (sequencer not busy)
//   start                one-cycle pulse to begin a reveal
//   len        [4:0]     number of characters to reveal
//   busy                 reveal in progress
//   done                 one-cycle pulse at reveal completion
//   char_code  [6:0]     glyph for the slot under pixel_x (to text_display)
//   x_pos      [9:0]     left edge of that slot (to text_display)
//   y_pos      [9:0]     top edge of the line (to text_display)
//
// MAX_CHARS must match the value given to the text_line_sequencer instance.
// -----------------------------------------------------------------------------
interface text_line_sequencer_if #(
  parameter int MAX_CHARS = 8
);
  localparam int AW = $clog2(MAX_CHARS);

  logic [9:0]    pixel_x;
  logic          frame_tick;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_char;
  logic          wr_ready;
  logic          start;
  logic [4:0]    len;
  logic          busy;
  logic          done;
  logic [6:0]    char_code;
  logic [9:0]    x_pos;
  logic [9:0]    y_pos;

  modport master (
    output pixel_x, frame_tick, wr_en, wr_addr, wr_char, start, len,
    input  wr_ready, busy, done, char_code, x_pos, y_pos
  );

  modport slave (
    input  pixel_x, frame_tick, wr_en, wr_addr, wr_char, start, len,
    output wr_ready, busy, done, char_code, x_pos, y_pos
  );
endinterface

// File: rtl/text_line_sequencer.sv
// -----------------------------------------------------------------------------
// text_line_sequencer
//
// Purpose:
//   Drives a single text_display glyph renderer across a horizontal line of
//   MAX_CHARS character slots. Holds a writable character buffer and a
//   typewriter-style reveal FSM paced by frame ticks. Every cycle it presents
//   char_code / x_pos / y_pos for the slot under the current pixel_x, so the
//   outputs can feed text_display directly.
//
// Parameters:
//   SCALE          font scale; slot width is 6*SCALE pixels
//   MAX_CHARS      buffer depth / slot count (2..16)
//   REVEAL_FRAMES  frame ticks per revealed character (>= 1)
//   BASE_X         left edge of slot 0
//   BASE_Y         top edge of the line
//
// Ports:
//   clk_0   pixel clock
//   rst     synchronous, active-low reset
//   bus     text_line_sequencer_if.slave (write port, reveal control,
//           pixel_x in, char_code/x_pos/y_pos out)
//
// Optional feature:
//   TEXT_SEQ_BLINK_EN  when defined, a blinking '_' cursor is shown in the
//                      next-to-be-revealed slot while a reveal is running.
// -----------------------------------------------------------------------------
module text_line_sequencer #(
  parameter int         SCALE         = 4,
  parameter int         MAX_CHARS     = 8,
  parameter int         REVEAL_FRAMES = 8,
  parameter logic [9:0] BASE_X        = 10'd0,
  parameter logic [9:0] BASE_Y        = 10'd0
) (
  input  logic                  clk_0,
  input  logic                  rst,
  text_line_sequencer_if.slave  bus
);

  localparam int         AW          = $clog2(MAX_CHARS);
  localparam int         FW          = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(REVEAL_FRAMES - 1);
  localparam logic [4:0] MAX_LEN     = 5'(MAX_CHARS);
  localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(MAX_CHARS);
  localparam logic [9:0] SLOT_W      = 10'(6 * SCALE);
  localparam logic [9:0] SLOT_COUNT  = 10'(MAX_CHARS);
  localparam logic [6:0] SPACE       = 7'h20;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REVEAL = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    visible_q, visible_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          done_q, done_d;
  logic [6:0]    buf_q [MAX_CHARS];
  logic [6:0]    buf_d [MAX_CHARS];

  logic          wrReady;
  logic          addrOk;
  logic [4:0]    lenClamped;
  logic [6:0]    cursorChar;

  logic [9:0]    rel;
  logic [9:0]    slot;
  logic [9:0]    slotBase;
  logic          inLine;
  logic [AW-1:0] slotIdx;
  logic [6:0]    charSel;
  logic [9:0]    xSel;

  assign wrReady    = (state_q != REVEAL);
  assign addrOk     = ({1'b0, bus.wr_addr} < ADDR_LIMIT);
  assign lenClamped = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;

  // Buffer next state: a write lands only when accepted and in range.
  always_comb begin
    buf_d = buf_q;
    if (bus.wr_en && wrReady && addrOk) begin
      buf_d[bus.wr_addr] = bus.wr_char;
    end
  end

  // Reveal FSM next state. A start in IDLE wins over a simultaneous tick
  // because IDLE never looks at frame_tick. A zero-length start finishes
  // immediately without leaving IDLE.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    visible_d = visible_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d     = lenClamped;
          visible_d = 5'd0;
          frame_d   = '0;
          if (lenClamped == 5'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = REVEAL;
          end
        end
      end
      REVEAL: begin
        if (bus.frame_tick) begin
          if (frame_q == FRAME_LAST) begin
            frame_d   = '0;
            visible_d = visible_q + 5'd1;
            if ((visible_q + 5'd1) == len_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers, including the character buffer, cleared to spaces.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= 5'd0;
      visible_q <= 5'd0;
      frame_q   <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < MAX_CHARS; i++) begin
        buf_q[i] <= SPACE;
      end
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      visible_q <= visible_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      for (int i = 0; i < MAX_CHARS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

`ifdef TEXT_SEQ_BLINK_EN
  localparam logic [6:0] CURSOR = 7'h5F;

  logic [4:0] blink_q, blink_d;

  // Free-running blink phase, advanced once per frame in every state.
  always_comb begin
    blink_d = blink_q;
    if (bus.frame_tick) begin
      blink_d = blink_q + 5'd1;
    end
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      blink_q <= 5'd0;
    end else begin
      blink_q <= blink_d;
    end
  end

  // The cursor only shows while a reveal is running; bit 4 gives a
  // 16-frames-on / 16-frames-off blink.
  assign cursorChar = ((state_q == REVEAL) && blink_q[4]) ? CURSOR : SPACE;
`else
  assign cursorChar = SPACE;
`endif

  // Slot select. rel is only meaningful when pixel_x >= BASE_X, which is
  // part of inLine, so the wrapped value for pixels left of the line is
  // never used.
  always_comb begin
    rel      = bus.pixel_x - BASE_X;
    slot     = rel / SLOT_W;
    slotBase = slot * SLOT_W;
    inLine   = (bus.pixel_x >= BASE_X) && (slot < SLOT_COUNT);
    slotIdx  = slot[AW-1:0];
    charSel  = SPACE;
    xSel     = BASE_X;
    if (inLine) begin
      xSel = BASE_X + slotBase;
      if (slot < {5'd0, visible_q}) begin
        charSel = buf_q[slotIdx];
      end else if (slot == {5'd0, visible_q}) begin
        charSel = cursorChar;
      end
    end
  end

  assign bus.wr_ready  = wrReady;
  assign bus.busy      = (state_q == REVEAL);
  assign bus.done      = done_q;
  assign bus.char_code = charSel;
  assign bus.x_pos     = xSel;
  assign bus.y_pos     = BASE_Y;

endmodule
